mm_cmd_sequencer: RTL

Sequences TPM commands into the management module from two requesters: port 0 is the host interface, port 1 is the self-test/maintenance agent.
- Arbitrates round-robin between them and holds command code and parameters stable.
- Issues a one-cycle start strobe, waits for completion or timeout, and routes the response code back to the originating requester.
- Sits between the command front-end and management_module.

---
 rtl/mm_pkg.sv | 21 ++
 rtl/mm_rr_arbiter2.sv | 25 ++
 rtl/mm_cmd_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared encodings for the management-module command sequencer: FSM states,
// TPM response codes and the command codes used by the top and its benches.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } mm_state_e;

  localparam logic [31:0] TPM_RC_SUCCESS    = 32'h0000_0000;
  localparam logic [31:0] TPM_RC_FAILURE    = 32'h0000_0101;
  localparam logic [31:0] TPM_RC_INITIALIZE = 32'h0000_0100;
  localparam logic [31:0] TPM_RC_VALUE      = 32'h0000_0084;
  localparam logic [31:0] TPM_RC_AUTH_TYPE  = 32'h0000_0124;

  localparam logic [31:0] TPM_CC_STARTUP    = 32'h0000_0144;
  localparam logic [31:0] TPM_CC_SHUTDOWN   = 32'h0000_0145;

endpackage

// File: rtl/mm_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that did not win last time. Purely combinational.
module mm_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt_onehot,
  output logic       gnt_idx
);

  always_comb begin
    gnt_onehot = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt_onehot = 2'b01;
        2'b10:   gnt_onehot = 2'b10;
        2'b11:   gnt_onehot = last_grant ? 2'b01 : 2'b10;
        default: gnt_onehot = 2'b00;
      endcase
    end
  end

  assign gnt_idx = gnt_onehot[1];

endmodule

// File: rtl/mm_cmd_sequencer.sv
// Arbitrates host and self-test commands into the management module, issues a
// start strobe, waits for done or timeout and routes the response code back.
module mm_cmd_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 10,
  parameter int unsigned TOCNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  input  logic [31:0]        req_cc0,
  input  logic [32:0]        req_param0,
  input  logic [31:0]        req_cc1,
  input  logic [32:0]        req_param1,
  output logic [1:0]         req_ready,
  output logic [1:0]         rsp_valid,
  output logic [31:0]        rsp_rc,
  output logic               mm_start,
  output logic [31:0]        mm_tpm_cc,
  output logic [32:0]        mm_cmd_param,
  input  logic               mm_done,
  input  logic [31:0]        mm_rc,
  output logic               busy,
  output logic [TOCNT_W-1:0] timeout_cnt,
  output logic [1:0]         dbg_state
);

  // Handshake: a request is accepted on any cycle where req_valid[n] and
  // req_ready[n] are both high; ready is offered only in IDLE, only to the
  // arbitration winner, and never while reset is asserted.

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  mm_state_e          state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        cc_q, cc_d;
  logic [32:0]        param_q, param_d;
  logic [31:0]        rsp_rc_q, rsp_rc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOCNT_W-1:0] tocnt_q, tocnt_d;

  logic [1:0]         arb_onehot;
  logic               arb_idx;

  mm_rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     ((state_q == ST_IDLE) && !reset),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    cc_d         = cc_q;
    param_d      = param_q;
    rsp_rc_d     = rsp_rc_q;
    cnt_d        = cnt_q;
    tocnt_d      = tocnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_onehot) begin
          gnt_d        = arb_idx;
          last_grant_d = arb_idx;
          cc_d         = arb_idx ? req_cc1 : req_cc0;
          param_d      = arb_idx ? req_param1 : req_param0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion on the terminal cycle beats the timeout.
        if (mm_done) begin
          rsp_rc_d = mm_rc;
          state_d  = ST_RESPOND;
        end else if (cnt_q == TERM_CNT) begin
          rsp_rc_d = TPM_RC_FAILURE;
          if (tocnt_q != '1) tocnt_d = tocnt_q + TOCNT_W'(1);
          state_d  = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cc_q         <= '0;
      param_q      <= '0;
      rsp_rc_q     <= '0;
      cnt_q        <= '0;
      tocnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cc_q         <= cc_d;
      param_q      <= param_d;
      rsp_rc_q     <= rsp_rc_d;
      cnt_q        <= cnt_d;
      tocnt_q      <= tocnt_d;
    end
  end

  // Strobes decode straight from state so reset removes them asynchronously.
  assign req_ready    = arb_onehot;
  assign mm_start     = (state_q == ST_ISSUE);
  assign rsp_valid    = (state_q == ST_RESPOND) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy         = (state_q != ST_IDLE);
  assign rsp_rc       = rsp_rc_q;
  assign mm_tpm_cc    = cc_q;
  assign mm_cmd_param = param_q;
  assign timeout_cnt  = tocnt_q;
  assign dbg_state    = state_q;

endmodule
